// File: rtl/poly_beeper.sv
// Polyphonic square-wave beeper: per-channel tone counters with glitch-free
// period updates, mixed to one output bit by a first-order sigma-delta stage.
module poly_beeper #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             mode,
  input  logic [CHANNELS*WIDTH-1:0]        manual_cycle,
  input  logic [CHANNELS*WIDTH-1:0]        auto_cycle,
  input  logic [CHANNELS-1:0]              chan_en,
  output logic                             beeper,
  output logic [CHANNELS-1:0]              ch_level,
  output logic [$clog2(CHANNELS+1)-1:0]    active_cnt
);

  localparam int SW = $clog2(CHANNELS + 1);
  localparam int AW = $clog2(2 * CHANNELS);

  logic                             mode_q;
  logic [CHANNELS-1:0][WIDTH-1:0]   cur_p_q, cur_p_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   sel_p;
  logic [AW-1:0]                    acc_q, acc_d;
  logic                             beeper_q, beeper_d;
  logic [SW-1:0]                    active_q, active_d;
  logic [CHANNELS-1:0]              level;
  logic [SW-1:0]                    sum;
  logic [AW:0]                      t;
  logic                             mode_change;

  assign mode_change = (mode != mode_q);

  always_comb begin
    sel_p = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_p[k] = mode ? auto_cycle[k*WIDTH +: WIDTH] : manual_cycle[k*WIDTH +: WIDTH];
    end
  end

  // New periods are only accepted while idle or on the wrap edge, so a tone
  // never gets a truncated or stretched cycle.
  always_comb begin
    cur_p_d  = cur_p_q;
    cnt_d    = cnt_q;
    level    = '0;
    sum      = '0;
    active_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      level[k] = (cur_p_q[k] != '0) && (cnt_q[k] < (cur_p_q[k] >> 1));
      sum      = sum + SW'(level[k]);
      active_d = active_d + SW'(cur_p_q[k] != '0);
      if (mode_change || !chan_en[k]) begin
        cnt_d[k]   = '0;
        cur_p_d[k] = '0;
      end else if (cur_p_q[k] == '0) begin
        cnt_d[k]   = '0;
        cur_p_d[k] = sel_p[k];
      end else if (cnt_q[k] == cur_p_q[k] - WIDTH'(1)) begin
        cnt_d[k]   = '0;
        cur_p_d[k] = sel_p[k];
      end else begin
        cnt_d[k]   = cnt_q[k] + WIDTH'(1);
      end
    end
  end

  // acc stays below CHANNELS, so acc + sum never exceeds 2*CHANNELS-1.
  always_comb begin
    t = {1'b0, acc_q} + (AW+1)'(sum);
    if (t >= (AW+1)'(CHANNELS)) begin
      beeper_d = 1'b1;
      acc_d    = AW'(t - (AW+1)'(CHANNELS));
    end else begin
      beeper_d = 1'b0;
      acc_d    = AW'(t);
    end
    if (mode_change) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      mode_q   <= mode;
      cur_p_q  <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      beeper_q <= 1'b0;
      active_q <= '0;
    end else begin
      mode_q   <= mode;
      cur_p_q  <= cur_p_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      beeper_q <= beeper_d;
      active_q <= active_d;
    end
  end

  assign beeper     = beeper_q;
  assign ch_level   = level;
  assign active_cnt = active_q;

endmodule
